// File: rtl/dmem_store_scheduler_pkg.sv
// Shared types for the data-memory store scheduler: queue entry payload,
// scheduler FSM state and the data-memory command bundle.
package dmem_store_scheduler_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int ROB_W  = 6;

  // Per-entry payload; valid/committed flags live in separate reset flops
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
    logic [ROB_W-1:0]  rob;
  } sq_entry_t;

  typedef enum logic [0:0] {
    ST_RUN       = 1'b0,
    ST_DRAIN_ALL = 1'b1
  } sched_state_t;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } dm_cmd_t;

  localparam dm_cmd_t DM_IDLE = '0;

endpackage

// File: rtl/dmem_store_scheduler_if.sv
// MEM-stage / ROB / data-memory signal bundle seen by the store scheduler.
interface dmem_store_scheduler_if;
  import dmem_store_scheduler_pkg::*;

  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_grant;
  logic              ld_stall;
  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic [BE_W-1:0]   st_be;
  logic [ROB_W-1:0]  st_rob;
  logic              sq_full;
  logic              commit_valid;
  logic [ROB_W-1:0]  commit_rob;
  logic              flush;
  logic              drain_all;
  logic              drain_done;
  logic              MemRead_2DM;
  logic              MemWrite_2DM;
  logic [BE_W-1:0]   MemWrite_BE;
  logic [ADDR_W-1:0] data_address_2DM;
  logic [DATA_W-1:0] data_write_2DM;

  modport slave (
    input  ld_req, ld_addr, st_valid, st_addr, st_data, st_be, st_rob,
           commit_valid, commit_rob, flush, drain_all,
    output ld_grant, ld_stall, sq_full, drain_done,
           MemRead_2DM, MemWrite_2DM, MemWrite_BE, data_address_2DM, data_write_2DM
  );

  modport master (
    output ld_req, ld_addr, st_valid, st_addr, st_data, st_be, st_rob,
           commit_valid, commit_rob, flush, drain_all,
    input  ld_grant, ld_stall, sq_full, drain_done,
           MemRead_2DM, MemWrite_2DM, MemWrite_BE, data_address_2DM, data_write_2DM
  );

endinterface

// File: rtl/dmem_store_scheduler_store_queue_cam.sv
// In-order store queue with ROB-tag commit match, word-address compare
// against the current load, and flush that keeps only committed entries.
module dmem_store_scheduler_store_queue_cam
  import dmem_store_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              enq_i,
  input  sq_entry_t         enq_ent_i,
  input  logic              deq_i,
  input  logic              commit_valid_i,
  input  logic [ROB_W-1:0]  commit_rob_i,
  input  logic              flush_i,
  input  logic [ADDR_W-3:0] ld_word_i,
  output logic              hit_o,
  output logic              full_o,
  output logic              head_rdy_o,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [BE_W-1:0]   head_be_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]    head_q, head_d, tail_q, tail_d, n_cmt;
  logic [DEPTH-1:0] vld_q, vld_d, cmt_q, cmt_d, cmt_hit;
  logic [IW-1:0]    head_idx, tail_idx;
  logic             enq_ok;
  sq_entry_t        ent_q [DEPTH];

  assign head_idx = head_q[IW-1:0];
  assign tail_idx = tail_q[IW-1:0];
  assign full_o   = (head_idx == tail_idx) && (head_q[IW] != tail_q[IW]);
  assign enq_ok   = enq_i && !full_o && !flush_i;

  assign head_rdy_o  = vld_q[head_idx] & cmt_q[head_idx];
  assign head_addr_o = ent_q[head_idx].addr;
  assign head_data_o = ent_q[head_idx].data;
  assign head_be_o   = ent_q[head_idx].be;

  always_comb begin
    hit_o   = 1'b0;
    cmt_hit = '0;
    n_cmt   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cmt_hit[i] = commit_valid_i && vld_q[i] && !cmt_q[i] && (ent_q[i].rob == commit_rob_i);
      if (vld_q[i] && (ent_q[i].addr[ADDR_W-1:2] == ld_word_i)) hit_o = 1'b1;
    end
    cmt_d = cmt_q | cmt_hit;
    // Committed entries are always the oldest, so their count locates the first uncommitted slot
    for (int i = 0; i < DEPTH; i++) n_cmt = n_cmt + PW'(vld_q[i] & cmt_d[i]);
    vld_d  = vld_q;
    head_d = head_q;
    tail_d = tail_q;
    if (deq_i) begin
      vld_d[head_idx] = 1'b0;
      cmt_d[head_idx] = 1'b0;
      head_d          = head_q + PW'(1);
    end
    if (flush_i) begin
      tail_d = head_q + n_cmt;
      vld_d  = vld_d & cmt_d;
      cmt_d  = vld_d & cmt_d;
    end else if (enq_ok) begin
      vld_d[tail_idx] = 1'b1;
      cmt_d[tail_idx] = 1'b0;
      tail_d          = tail_q + PW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      head_q <= '0;
      tail_q <= '0;
      vld_q  <= '0;
      cmt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      vld_q  <= vld_d;
      cmt_q  <= cmt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (enq_ok) ent_q[tail_idx] <= enq_ent_i;
  end

endmodule

// File: rtl/dmem_store_scheduler.sv
// Arbitrates the single data-memory port between MEM-stage loads and
// committed buffered stores, with anti-starvation and full-drain modes.
module dmem_store_scheduler
  import dmem_store_scheduler_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  dmem_store_scheduler_if.slave   mem_io
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  sched_state_t      state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              hit, full, head_rdy, conflict;
  logic              drain, grant, stall, done;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [BE_W-1:0]   head_be;
  sq_entry_t         enq_ent;
  dm_cmd_t           cmd;

  assign enq_ent.addr = mem_io.st_addr;
  assign enq_ent.data = mem_io.st_data;
  assign enq_ent.be   = mem_io.st_be;
  assign enq_ent.rob  = mem_io.st_rob;

  dmem_store_scheduler_store_queue_cam #(.DEPTH(DEPTH)) u_sq (
    .CLK            (CLK),
    .RESET          (RESET),
    .enq_i          (mem_io.st_valid),
    .enq_ent_i      (enq_ent),
    .deq_i          (drain),
    .commit_valid_i (mem_io.commit_valid),
    .commit_rob_i   (mem_io.commit_rob),
    .flush_i        (mem_io.flush),
    .ld_word_i      (mem_io.ld_addr[ADDR_W-1:2]),
    .hit_o          (hit),
    .full_o         (full),
    .head_rdy_o     (head_rdy),
    .head_addr_o    (head_addr),
    .head_data_o    (head_data),
    .head_be_o      (head_be)
  );

  assign conflict = mem_io.ld_req && hit;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    drain    = 1'b0;
    grant    = 1'b0;
    stall    = 1'b0;
    done     = 1'b0;
    cmd      = DM_IDLE;
    case (state_q)
      ST_RUN: begin
        if (mem_io.drain_all) state_d = ST_DRAIN_ALL;
        if (head_rdy && (starve_q == SW'(STARVE_LIMIT))) begin
          drain = 1'b1;
          stall = mem_io.ld_req;
        end else if (mem_io.ld_req && !conflict) begin
          grant = 1'b1;
        end else begin
          // Port is free when the load is absent or blocked by a pending store
          stall = mem_io.ld_req;
          drain = head_rdy;
        end
      end
      ST_DRAIN_ALL: begin
        stall = mem_io.ld_req;
        if (head_rdy) begin
          drain = 1'b1;
        end else begin
          done    = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (grant) begin
      cmd.rd   = 1'b1;
      cmd.addr = mem_io.ld_addr;
    end else if (drain) begin
      cmd.wr    = 1'b1;
      cmd.be    = head_be;
      cmd.addr  = head_addr;
      cmd.wdata = head_data;
    end
    if (drain) starve_d = '0;
    else if (grant && head_rdy && (starve_q != SW'(STARVE_LIMIT))) starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_RUN;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  assign mem_io.ld_grant         = grant;
  assign mem_io.ld_stall         = stall;
  assign mem_io.sq_full          = full;
  assign mem_io.drain_done       = done;
  assign mem_io.MemRead_2DM      = cmd.rd;
  assign mem_io.MemWrite_2DM     = cmd.wr;
  assign mem_io.MemWrite_BE      = cmd.be;
  assign mem_io.data_address_2DM = cmd.addr;
  assign mem_io.data_write_2DM   = cmd.wdata;

endmodule

// File: doc/dmem_store_scheduler.md
# dmem_store_scheduler

Owns the single data-memory port shared by MEM-stage loads and buffered stores. Stores leave MEM into a small in-order store queue, are marked committed when the ROB retires them, and drain to data memory in cycles the port is not needed by a load. Sits between the MEM stage and data memory, replacing the direct MemRead/MemWrite drive from MEM.

## Interface
- DEPTH, 4: store queue entries (power of two, ≥2)
- STARVE_LIMIT, 8: consecutive load-granted cycles with a committed store waiting before one drain is forced

- CLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- ld_req  in  1  MEM-stage load wants the port this cycle
- ld_addr  in  32  load byte address
- ld_grant  out  1  load owns the port this cycle; data returns combinationally from DM
- ld_stall  out  1  load must hold (conflict, forced drain, or DRAIN_ALL)
- st_valid  in  1  enqueue store
- st_addr  in  32  store byte address
- st_data  in  32  store data, already lane-aligned
- st_be  in  4  byte enables
- st_rob  in  6  ROB pointer of the store
- sq_full  out  1  queue full; enqueue ignored, MEM must freeze
- commit_valid  in  1  ROB retiring an instruction
- commit_rob  in  6  ROB pointer retired
- flush  in  1  squash all uncommitted entries
- drain_all  in  1  request full drain (syscall/halt)
- drain_done  out  1  one-cycle pulse when DRAIN_ALL completes
- MemRead_2DM  out  1  DM read strobe
- MemWrite_2DM  out  1  DM write strobe
- MemWrite_BE  out  4  DM byte enables
- data_address_2DM  out  32  DM address
- data_write_2DM  out  32  DM write data

## Operation
- Entry: valid, committed, addr, data, be, rob. FIFO head/tail pointers, log2(DEPTH)+1 bits for full/empty.
- Commit: every valid, uncommitted entry with rob == commit_rob sets committed. No match: ignored. Only entries valid at the start of the cycle are compared.
- Conflict: ld_req with ld_addr[31:2] equal to any valid entry's addr[31:2] → ld_stall=1, ld_grant=0. No forwarding.
- Port priority in RUN: (1) forced drain when starve_cnt == STARVE_LIMIT and head committed; (2) conflict-free load; (3) drain head when committed. Only one access per cycle.
- starve_cnt: increments when load granted and head committed; clears on any drain; saturates at STARVE_LIMIT.
- Flush: tail ← first uncommitted slot (committed entries are always oldest). Committed entries are kept. A same-cycle enqueue is discarded.
- FSM: RUN → DRAIN_ALL on drain_all. DRAIN_ALL: loads stalled, committed head drained every cycle; when queue empty or head uncommitted, pulse drain_done and return to RUN.
- Idle port: all DM outputs 0.

## Timing
- Reset: queue empty, FSM RUN, starve_cnt 0; all outputs 0 except sq_full=0, ld_stall=0.
- DM outputs and ld_grant/ld_stall are combinational from registered queue/FSM state plus current ld_req/ld_addr; the DM write commits at the next CLK edge, and head advances on that same edge.
- Enqueue latency: entry visible to conflict check and commit the cycle after st_valid.
- Simultaneous drain and enqueue when full: drain frees the slot at the edge, but sq_full was 1 for that cycle, so the enqueue is ignored.
- Pointer wrap: modulo DEPTH, with the extra MSB distinguishing full from empty.
- RESET mid-DRAIN_ALL: queue discarded, no drain_done.

## Structure
- Shared package: entry struct, FSM state enum, DM strobe constants.
- Natural sub-module: store_queue_cam (FIFO storage, commit match, address compare, flush tail restore). Arbitration, starve counter and FSM live in the top.

## Test plan
- Enqueue store 0x100/0xDEADBEEF rob 5, commit 5, no loads → next cycle MemWrite_2DM=1, addr 0x100, data 0xDEADBEEF.
- Uncommitted store at 0x104, load 0x106 → ld_stall=1. After commit and drain, the load is granted.
- Fill 4 entries → sq_full=1 and a 5th st_valid is dropped. One drain later the enqueue is accepted.
- Committed head with continuous conflict-free loads, STARVE_LIMIT=8 → 8 loads granted, 9th cycle ld_stall=1 and a write is issued.
- Entries rob 1,2,3, commit 1, flush → only rob 1 remains and drains; tail restored.
- drain_all with 3 committed entries → 3 writes on consecutive cycles, drain_done pulse in the cycle after the last, loads stalled throughout.
